// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, retries on timeout
// and releases the core resets in order. Define PLL_SEQ_STATUS_EN to add status/retry_cnt ports.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_GAP     = 64,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic                  fault
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [2:0]            status,
    output logic [7:0]            retry_cnt
`endif
);

    localparam int MAX_A    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W    = $clog2(MAX_RETRIES + 1);
    localparam int LAST_IDX = (NUM_STAGES > 1) ? NUM_STAGES - 2 : 0;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0]   stage_q, stage_d;
    logic                    ready_q, ready_d;
    logic                    fault_q, fault_d;
    logic [1:0]              sync_q;
    logic                    lock_s;

    assign lock_s = sync_q[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            stage_q   <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            stage_q   <= stage_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            sync_q    <= {sync_q[0], locked};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_d   = retry_q;
        pll_rst_d = pll_rst_q;
        stage_d   = stage_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
        if (restart) begin
            state_d   = S_RESET_PLL;
            cnt_d     = '0;
            retry_d   = '0;
            pll_rst_d = 1'b1;
            stage_d   = '0;
            ready_d   = 1'b0;
            fault_d   = 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    pll_rst_d = 1'b1;
                    if (cnt_q == RST_LAST) begin
                        pll_rst_d = 1'b0;
                        state_d   = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen on the final timeout cycle still wins over the retry.
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TMO_LAST) begin
                        retry_d   = retry_q + 1'b1;
                        pll_rst_d = 1'b1;
                        if (retry_q == RTY_LAST) begin
                            fault_d = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_RESET_PLL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STB_LAST) begin
                        stage_d[0] = 1'b1;
                        if (NUM_STAGES == 1) begin
                            ready_d = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        stage_d   = '0;
                        pll_rst_d = 1'b1;
                        state_d   = S_RESET_PLL;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        for (int i = 1; i < NUM_STAGES; i++) begin
                            stage_d[i] = stage_q[i-1];
                        end
                        if (stage_q[LAST_IDX]) begin
                            ready_d = 1'b1;
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q;
                    if (!lock_s) begin
                        stage_d   = '0;
                        ready_d   = 1'b0;
                        pll_rst_d = 1'b1;
                        retry_d   = '0;
                        state_d   = S_RESET_PLL;
                    end
                end
                S_FAULT: begin
                    cnt_d     = cnt_q;
                    pll_rst_d = 1'b1;
                    stage_d   = '0;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                end
                default: begin
                    pll_rst_d = 1'b1;
                    stage_d   = '0;
                    ready_d   = 1'b0;
                    state_d   = S_RESET_PLL;
                end
            endcase
            if (state_d != state_q) begin
                cnt_d = '0;
            end
        end
    end

    assign pll_rst     = pll_rst_q;
    assign stage_rst_n = stage_q;
    assign ready       = ready_q;
    assign fault       = fault_q;

`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] retry_cnt_q, retry_cnt_d;
    logic [7:0] lose_cnt_q, lose_cnt_d;

    always_comb begin
        retry_cnt_d = (32'(retry_d) > 255) ? 8'hFF : 8'(retry_d);
        lose_cnt_d  = lose_cnt_q;
        // Lock loss in RUN counts only when a restart is not overriding it.
        if (!restart && state_q == S_RUN && !lock_s && lose_cnt_q != 8'hFF) begin
            lose_cnt_d = lose_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt_q <= '0;
            lose_cnt_q  <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            lose_cnt_q  <= lose_cnt_d;
        end
    end

    assign status    = state_q;
    assign retry_cnt = retry_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with randomized lock timing, expected
// outputs derived arithmetically from edge numbers (k = index of the last refclk rising edge).
module tb_pll_reset_sequencer;

    localparam int RST    = 4;
    localparam int TMO    = 20;
    localparam int STB    = 8;
    localparam int NS     = 3;
    localparam int GAP    = 3;
    localparam int MR     = 2;
    localparam int PERIOD = RST + TMO;
    localparam int NONE   = -1000;

    logic          refclk  = 1'b0;
    logic          rst_n   = 1'b1;
    logic          locked  = 1'b0;
    logic          restart = 1'b0;
    logic          pll_rst;
    logic [NS-1:0] stage_rst_n;
    logic          ready;
    logic          fault;
`ifdef PLL_SEQ_STATUS_EN
    logic [2:0]    status;
    logic [7:0]    retry_cnt;
`endif

    int          k;
    int          errors;
    int          checks;
    logic [31:0] exp_q[$];

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .NUM_STAGES    (NS),
        .STAGE_GAP     (GAP),
        .MAX_RETRIES   (MR)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .locked      (locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .stage_rst_n (stage_rst_n),
        .ready       (ready),
        .fault       (fault)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .status      (status),
        .retry_cnt   (retry_cnt)
`endif
    );

    // clock / reset block
    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic pll_e, input logic [NS-1:0] st_e,
                             input logic rdy_e, input logic flt_e);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'(pll_e));
        chk({tag, "_stage"}, 32'(stage_rst_n), 32'(st_e));
        chk({tag, "_ready"}, 32'(ready), 32'(rdy_e));
        chk({tag, "_fault"}, 32'(fault), 32'(flt_e));
    endtask

    task automatic next_edge();
        @(negedge refclk);
        k++;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #2;
        rst_n   = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        #1;
        check_all("rst_async", 1'b1, '0, 1'b0, 1'b0);
        repeat (3) @(negedge refclk);
        check_all("rst_hold", 1'b1, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        k     = -1;
    endtask

    function automatic logic lock_at(input int e, input int s, input int g);
        return (e >= s) && (e != g);
    endfunction

    // Bring-up from RESET_PLL entered at edge t; locked sampled 1 from edge s except edge g.
    // Release needs STB+1 consecutive high samples of locked; bit i rises 2+STB+i*GAP after the run starts.
    task automatic up_phase(input int t, input int s, input int g, input int k_end);
        int            a;
        logic [NS-1:0] st;
        a = (g >= s) ? g + 1 : s;
        exp_q.delete();
        for (int i = 0; i < NS; i++) exp_q.push_back(32'(a + STB + 2 + i * GAP));
        while (k < k_end) begin
            locked = lock_at(k + 1, s, g);
            next_edge();
            for (int i = 0; i < NS; i++) st[i] = (k >= int'(exp_q[i]));
            check_all("up", (k < t + RST), st, (k >= int'(exp_q[NS-1])), 1'b0);
        end
    endtask

    // locked held low: RST cycles of pll_rst then TMO cycles waiting, MR times, then fault.
    task automatic tmo_phase(inout int t, input int k_end, input int rst_at);
        int   rel;
        logic flt;
        while (k < k_end) begin
            locked  = 1'b0;
            restart = (k + 1 == rst_at);
            next_edge();
            restart = 1'b0;
            if (k == rst_at) t = k;
            rel = k - t;
            flt = (rel >= MR * PERIOD);
            check_all("tmo", flt || ((rel % PERIOD) < RST), '0, 1'b0, flt);
        end
    endtask

    // Drop locked: outputs hold for the two synchronizer edges, then everything resets.
    task automatic lock_drop(input logic [NS-1:0] hold, output int t);
        locked = 1'b0;
        repeat (2) begin
            next_edge();
            check_all("hold", 1'b0, hold, &hold, 1'b0);
        end
        next_edge();
        t = k;
        check_all("drop", 1'b1, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int t;
        int s;
        int g;
        errors = 0;
        checks = 0;
        k      = -1;

        // nominal bring-up, lock from edge 10
        do_reset();
        up_phase(-1, 10, NONE, 30);

        // lock loss in RUN, then relock at a random point of the next wait
        lock_drop('1, t);
        s = t + $urandom_range(3, 21);
        up_phase(t, s, NONE, s + 20);

        // one-cycle lock glitch during the stability window
        do_reset();
        s = $urandom_range(2, 12);
        g = s + $urandom_range(1, 8);
        up_phase(-1, s, g, g + 21);

        // lock loss during release: no retry charged, so two full timeouts before fault
        do_reset();
        s = $urandom_range(2, 21);
        up_phase(-1, s, NONE, s + STB + 2);
        lock_drop(NS'(1), t);
        tmo_phase(t, t + MR * PERIOD + 4, NONE);

        // timeouts to fault, restart in fault, restart colliding with a timeout
        do_reset();
        t = -1;
        tmo_phase(t, 60, 55);
        tmo_phase(t, t + 30, t + PERIOD);
        tmo_phase(t, t + PERIOD, NONE);

        // one retry charged, then lock and run; lock loss in RUN must clear the retry count
        t = k;
        s = t + $urandom_range(3, 21);
        up_phase(t, s, NONE, s + 20);
        lock_drop('1, t);
        tmo_phase(t, t + MR * PERIOD + 4, NONE);

        // asynchronous reset between stage 0 and stage 1 release
        do_reset();
        s = $urandom_range(2, 21);
        up_phase(-1, s, NONE, s + STB + 3);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Single-clock controller on the 50 MHz reference domain that sequences the core PLL. Main tasks:
- drives the PLL reset;
- waits for and qualifies `locked`;
- retries on lock timeout;
- releases per-domain core resets in a fixed order.

It sits between the board reset and the PLL/core reset tree. It reports `ready`, or `fault` after retries are exhausted.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before an attempt fails.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- NUM_STAGES, 3: number of sequenced reset outputs (1..8).
- STAGE_GAP, 64: cycles between successive stage releases (≥1).
- MAX_RETRIES, 7: failed attempts tolerated before FAULT (≥1).

Ports:
- refclk, input, 1: reference clock; the only clock.
- rst_n, input, 1: asynchronous active-low reset.
- locked, input, 1: PLL lock; asynchronous to refclk.
- restart, input, 1: synchronous single-cycle request to restart the whole sequence.
- pll_rst, output, 1: active-high reset to the PLL.
- stage_rst_n, output, NUM_STAGES: active-low core resets; bit 0 is released first.
- ready, output, 1: all stages released and lock held.
- fault, output, 1: MAX_RETRIES attempts failed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pll_rst=1, stage_rst_n=all 0, ready=0, fault=0.
  - state=RESET_PLL; counter, retry count and sync flops cleared.
- All outputs are registered.
- `locked` passes through a 2-flop synchronizer → lock_s, adding 2 cycles of latency. No other input is synchronized.
- Counter width is clog2 of the largest of the counted parameters. It is cleared on every state change.
- RESET_PLL:
  - pll_rst=1 for exactly RST_CYCLES cycles.
  - Then → WAIT_LOCK; pll_rst=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s=1 → STABLE.
  - Counter reaching LOCK_TIMEOUT-1 with lock_s=0 → retry count +1.
    - If the count now equals MAX_RETRIES → FAULT.
    - Otherwise → RESET_PLL.
- STABLE:
  - lock_s must stay 1 for STABLE_CYCLES consecutive cycles, then → RELEASE.
  - Any lock_s=0 → WAIT_LOCK with a fresh timeout. This does not count as a retry.
- RELEASE:
  - stage_rst_n[0] goes high on entry.
  - Each further bit i goes high STAGE_GAP cycles after bit i-1.
  - ready=1 and → RUN in the same cycle the last bit rises.
  - lock_s=0 at any point → all stage_rst_n=0, → RESET_PLL. Retry count is not incremented.
- RUN:
  - Hold all outputs.
  - lock_s=0 → next cycle: stage_rst_n=all 0, ready=0, pll_rst=1, retry count cleared, → RESET_PLL.
- FAULT:
  - pll_rst=1, stage_rst_n=all 0, ready=0, fault=1.
  - Leave only via restart or rst_n.
- restart=1 in any state:
  - Highest priority over every other transition in the same cycle.
  - Next cycle: state=RESET_PLL, counter=0, retry count=0, fault=0, ready=0, stage_rst_n=all 0, pll_rst=1.
- Invariant: stage_rst_n is never nonzero while pll_rst=1.
- Invariant: ready=1 implies stage_rst_n all 1.

Optional Feature:
PLL_SEQ_STATUS_EN.
- Defined: adds output ports `status[2:0]` (state encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5) and `retry_cnt[7:0]`.
  - retry_cnt is the current retry count, saturating at 255.
  - lose_cnt[7:0] counts RUN→RESET_PLL lock-loss events, saturating at 255. It is cleared only by rst_n.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=3, MAX_RETRIES=2. Edge E = the first refclk edge sampling locked=1.
1. Nominal bring-up: release rst_n at edge 0; locked=1 from edge 10.
   - pll_rst high for edges 0–3.
   - stage_rst_n bits 0/1/2 rise at E+2+8, +3, +6.
   - ready rises with bit 2.
   - fault stays 0.
2. Lock glitch in STABLE: locked drops 1 cycle at E+5, then returns.
   - No stage release until 8 new consecutive lock_s cycles.
   - pll_rst stays 0; retry count unchanged.
3. Timeout/fault: locked held 0.
   - Two attempts, each with pll_rst high 4 cycles then 20 WAIT_LOCK cycles.
   - fault=1 after the 2nd timeout; pll_rst=1; stage_rst_n=000.
4. Lock loss in RUN: drop locked after ready=1.
   - 3 cycles later (2 sync + 1): stage_rst_n=000, ready=0, pll_rst=1.
   - Full sequence repeats once locked returns.
5. Restart priority: pulse restart in FAULT, and again in the same cycle a WAIT_LOCK timeout fires.
   - Both cases: fault=0, state RESET_PLL, retry count 0, pll_rst high 4 cycles.
6. Async reset mid-RELEASE: assert rst_n=0 between bit 0 and bit 1.
   - Outputs go to reset values immediately, without a clock edge.
